// File: rtl/eth_frame_pattern_tx_if.sv
// eth_frame_pattern_tx_if: byte-wide AXI4-Stream link between the pattern transmitter (master) and the TEMAC TX sink (slave)
interface eth_frame_pattern_tx_if;
  logic [7:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, output tlast, output tvalid, input tready);
  modport slave(input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_frame_pattern_tx.sv
// eth_frame_pattern_tx: pattern-memory driven Ethernet frame transmitter onto byte AXIS (ETH_FRAME_TX_SEQNUM_EN inserts tx_count at bytes 14-17)
module eth_frame_pattern_tx #(
  parameter int ADDR_WIDTH = 11,
  parameter int MIN_SIZE = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic continuous,
  input  logic [ADDR_WIDTH-1:0] frame_size,
  input  logic [15:0] ifg_cycles,
  output logic busy,
  output logic [31:0] tx_count,
  output logic [ADDR_WIDTH-1:0] pattern_addr,
  input  logic [7:0] pattern_data,
  input  logic [7:0] pattern_flags,
  eth_frame_pattern_tx_if.master m_axis
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} st_t;
  localparam logic [ADDR_WIDTH-1:0] MIN_SZ = ADDR_WIDTH'(MIN_SIZE);
  st_t st_q, st_d;
  logic [ADDR_WIDTH-1:0] eff_q, eff_d, addr_q, addr_d, off_q, off_d;
  logic [15:0] ifg_q, ifg_d, gap_q, gap_d;
  logic pend_q, pend_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] cnt_q, cnt_d, cnt_a;
  logic [8:0] f0_q, f0_d, f1_q, f1_d;
  logic [31:0] txc_q, txc_d;
  logic busy_q, busy_d;
  logic pop, last_pop, iss, latch;
  logic [7:0] byte_w;
  logic [8:0] w;
`ifdef ETH_FRAME_TX_SEQNUM_EN
  logic [1:0] sidx;
`endif
  always_comb begin
    pop = (cnt_q != 2'd0) && m_axis.tready;
    last_pop = pop && f0_q[8];
    cnt_a = cnt_q - {1'b0, pop};
    iss = (st_q == SEND) && (addr_q != eff_q) && ((cnt_a + {1'b0, pend_q}) < 2'd2);
    latch = ((st_q == IDLE) && start) || ((st_q == GAP) && (gap_q <= 16'd1) && continuous);
    byte_w = pattern_flags[0] ? lfsr_q : pattern_data;
`ifdef ETH_FRAME_TX_SEQNUM_EN
    sidx = off_q[1:0] - 2'd2;
    byte_w = ((off_q >= ADDR_WIDTH'(14)) && (off_q <= ADDR_WIDTH'(17))) ? txc_q[{~sidx, 3'b000} +: 8] : byte_w;
`endif
    w = {off_q == eff_q - 1'b1, byte_w};
    f0_d = pop ? f1_q : f0_q;
    f1_d = f1_q;
    f0_d = (pend_q && cnt_a == 2'd0) ? w : f0_d;
    f1_d = (pend_q && cnt_a != 2'd0) ? w : f1_d;
    cnt_d = cnt_a + {1'b0, pend_q};
    lfsr_d = pend_q ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    pend_d = iss;
    off_d = iss ? addr_q : off_q;
    addr_d = latch ? '0 : iss ? addr_q + 1'b1 : addr_q;
    txc_d = txc_q + {31'd0, last_pop};
    st_d = latch ? SEND : ((st_q == SEND) && last_pop) ? GAP : ((st_q == GAP) && (gap_q <= 16'd1)) ? IDLE : st_q;
    eff_d = latch ? ((frame_size < MIN_SZ) ? MIN_SZ : frame_size) : eff_q;
    ifg_d = latch ? ifg_cycles : ifg_q;
    gap_d = ((st_q == SEND) && last_pop) ? ifg_q : (st_q == GAP) ? gap_q - 16'd1 : gap_q;
    busy_d = st_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
      eff_q <= MIN_SZ;
      ifg_q <= '0;
      gap_q <= '0;
      addr_q <= '0;
      off_q <= '0;
      pend_q <= 1'b0;
      lfsr_q <= 8'h0B;
      cnt_q <= '0;
      f0_q <= '0;
      f1_q <= '0;
      txc_q <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      eff_q <= eff_d;
      ifg_q <= ifg_d;
      gap_q <= gap_d;
      addr_q <= addr_d;
      off_q <= off_d;
      pend_q <= pend_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
      txc_q <= txc_d;
      busy_q <= busy_d;
    end
  end
  assign m_axis.tdata = f0_q[7:0];
  assign m_axis.tlast = f0_q[8];
  assign m_axis.tvalid = cnt_q != 2'd0;
  assign pattern_addr = addr_q;
  assign tx_count = txc_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_eth_frame_pattern_tx.sv
// tb_eth_frame_pattern_tx: randomized scoreboard bench for eth_frame_pattern_tx against a frame-level reference model
module tb_eth_frame_pattern_tx;
  localparam int AW = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [AW-1:0] frame_size = '0;
  logic [15:0] ifg_cycles = '0;
  logic busy;
  logic [31:0] tx_count;
  logic [AW-1:0] pattern_addr;
  logic [7:0] pattern_data, pattern_flags;
  logic [7:0] mem [2048];
  logic [7:0] flg [2048];
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];
  int gaps [$];
  int frames_done = 0;
  int beat_in_frame = 0;
  int gap_len = 0;
  bit in_gap = 0;
  bit meas = 0;
  bit rnd_ready = 0;
  logic [7:0] m_lfsr = 8'h0B;
  logic [31:0] m_txc = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [8:0] pb = '0;
  eth_frame_pattern_tx_if axis();
  eth_frame_pattern_tx #(.ADDR_WIDTH(AW), .MIN_SIZE(60)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .frame_size(frame_size), .ifg_cycles(ifg_cycles), .busy(busy), .tx_count(tx_count),
    .pattern_addr(pattern_addr), .pattern_data(pattern_data), .pattern_flags(pattern_flags),
    .m_axis(axis)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pattern_data <= mem[pattern_addr];
    pattern_flags <= flg[pattern_addr];
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic logic [7:0] lfsr_next(logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
  task automatic push_frame(int size);
    int eff;
    eff = size < 60 ? 60 : size;
    for (int i = 0; i < eff; i++) begin
      logic [7:0] d;
      d = flg[i][0] ? m_lfsr : mem[i];
`ifdef ETH_FRAME_TX_SEQNUM_EN
      if (i >= 14 && i <= 17) d = m_txc[8*(17-i) +: 8];
`endif
      m_lfsr = lfsr_next(m_lfsr);
      exp_q.push_back({i == eff - 1, d});
    end
    m_txc++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask
  task automatic one_shot(int size, int ifg, bit rr);
    frame_size = AW'(size);
    ifg_cycles = 16'(ifg);
    continuous = 1'b0;
    rnd_ready = rr;
    push_frame(size);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("addr_first", pattern_addr, 0);
    chk("lat_cycle1_valid", axis.tvalid, 0);
    tick();
    chk("lat_cycle2_valid", axis.tvalid, 0);
    tick();
    chk("lat_cycle3_valid", axis.tvalid, 1);
    wait_idle(10000);
    chk("tx_count", tx_count, m_txc);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic run_cont(int n, int size, int ifg);
    int base, t;
    frame_size = AW'(size);
    ifg_cycles = 16'(ifg);
    continuous = 1'b1;
    rnd_ready = 0;
    base = frames_done;
    for (int k = 0; k < n; k++) push_frame(size);
    gaps.delete();
    meas = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(frames_done == base + n - 1 && beat_in_frame >= 3) && t < 20000) begin
      tick();
      t++;
    end
    chk("cont_last_frame_reached", frames_done, base + n - 1);
    continuous = 1'b0;
    wait_idle(5000);
    meas = 0;
    chk("cont_tx_count", tx_count, m_txc);
    chk("cont_frames", frames_done, base + n);
    chk("gap_count", gaps.size(), n - 1);
    foreach (gaps[i]) chk("gap_len", gaps[i], (ifg == 0 ? 1 : ifg) + 2);
    chk("cont_queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      in_gap = 0;
      beat_in_frame = 0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", axis.tvalid, 1);
        chk("stall_beat", {axis.tlast, axis.tdata}, pb);
      end
      if (!busy) in_gap = 0;
      if (in_gap && !axis.tvalid) gap_len++;
      if (in_gap && axis.tvalid) begin
        if (meas) gaps.push_back(gap_len);
        in_gap = 0;
      end
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", {axis.tlast, axis.tdata});
        end else chk("beat", {axis.tlast, axis.tdata}, exp_q.pop_front());
        beat_in_frame++;
        if (axis.tlast) begin
          frames_done++;
          beat_in_frame = 0;
          in_gap = 1;
          gap_len = 0;
        end
      end
      pv = axis.tvalid;
      pr = axis.tready;
      pb = {axis.tlast, axis.tdata};
    end
  end
  initial begin
    int t;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i);
      flg[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_addr", pattern_addr, 0);
    chk("rst_tx_count", tx_count, 0);
    rst_n = 1'b1;
    tick();
    one_shot(64, 0, 0);
    one_shot(10, 3, 0);
    for (int i = 0; i < 2048; i++) flg[i] = 8'hFF;
    one_shot(60, 0, 0);
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'($urandom);
      flg[i] = 8'($urandom);
    end
    one_shot(2047, 1, 1);
    for (int k = 0; k < 4; k++) one_shot($urandom_range(0, 300), $urandom_range(0, 8), 1);
    run_cont(3, 64, 12);
    run_cont(2, 60, 0);
    frame_size = AW'(200);
    rnd_ready = 0;
    push_frame(200);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (beat_in_frame < 20 && t < 1000) begin
      tick();
      t++;
    end
    chk("midframe_reached", beat_in_frame >= 20, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_tvalid", axis.tvalid, 0);
    chk("midrst_tx_count", tx_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", pattern_addr, 0);
    chk("midrst_tdata", axis.tdata, 0);
    exp_q.delete();
    m_lfsr = 8'h0B;
    m_txc = 0;
    tick();
    rst_n = 1'b1;
    tick();
    one_shot(60, 2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
